item_memory_mp: RTL and testbench

ITEM_MEMORY_MP -- requirements
Module: item_memory_mp

---
 rtl/item_memory_mp.sv | 257 +++++++++++++++++++++++++
 tb/tb_item_memory_mp.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/item_memory_mp.sv
// Multi-port hypervector item memory.
// Each lookup port returns either a CA90-generated item hypervector or a
// continuous-item-memory (CiM) level hypervector. A request can ask for
// several consecutive segments (dimensional expansion), streamed one per cycle
// through a valid/ready output register.

// CiM level generator. The base vector is the CA90 expansion of the seed.
// Level L inverts the lowest L bits of the base vector. The top level flips
// almost half the vector, so the extreme levels are close to orthogonal.
module cim #(
    parameter int HVDimension = 512,
    parameter int SeedWidth   = 32,
    parameter int CimSelWidth = $clog2(HVDimension/2)
) (
    input  logic [SeedWidth-1:0]   i_seed,
    input  logic [CimSelWidth-1:0] i_level,
    output logic [HVDimension-1:0] o_hv
);
    logic [HVDimension-1:0] w_base;
    logic [HVDimension-1:0] w_mask;

    // Chunk 0 is the seed. Each later chunk is one CA90 step of the chunk
    // before it: next[i] = cur[i-1] ^ cur[i+1], with circular neighbours.
    function automatic logic [HVDimension-1:0] ca90Expand(input logic [SeedWidth-1:0] seed);
        logic [SeedWidth-1:0] cur;
        ca90Expand = '0;
        cur = seed;
        for (int c = 0; c < HVDimension/SeedWidth; c++) begin
            ca90Expand[c*SeedWidth +: SeedWidth] = cur;
            cur = {cur[0], cur[SeedWidth-1:1]} ^ {cur[SeedWidth-2:0], cur[SeedWidth-1]};
        end
    endfunction

    // Build the level vector by inverting the lowest i_level bits of the base vector.
    always_comb begin
        w_base = ca90Expand(i_seed);
        for (int i = 0; i < HVDimension; i++) begin
            w_mask[i] = (i < int'(i_level));
        end
        o_hv = w_base ^ w_mask;
    end
endmodule

// Dual-sided CA90 item memory.
// The upper address bits pick a seed bank. That bank's CA90-expanded base
// vector is rotated left by the address offset within the bank.
module ca90_item_memory #(
    parameter int HVDimension  = 512,
    parameter int NumTotIm     = 1024,
    parameter int NumPerImBank = 128,
    parameter int SeedWidth    = 32,
    parameter int ImAddrWidth  = $clog2(NumTotIm),
    parameter int NumImSets    = NumTotIm/NumPerImBank
) (
    input  logic [NumImSets-1:0][SeedWidth-1:0] i_seeds,
    input  logic [ImAddrWidth-1:0]              i_addr_a,
    input  logic [ImAddrWidth-1:0]              i_addr_b,
    output logic [HVDimension-1:0]              o_hv_a,
    output logic [HVDimension-1:0]              o_hv_b
);
    localparam int IdxWidth = $clog2(NumPerImBank);

    logic [HVDimension-1:0] w_baseHv [NumImSets];

    // Chunk 0 is the seed. Each later chunk is one CA90 step of the chunk
    // before it: next[i] = cur[i-1] ^ cur[i+1], with circular neighbours.
    function automatic logic [HVDimension-1:0] ca90Expand(input logic [SeedWidth-1:0] seed);
        logic [SeedWidth-1:0] cur;
        ca90Expand = '0;
        cur = seed;
        for (int c = 0; c < HVDimension/SeedWidth; c++) begin
            ca90Expand[c*SeedWidth +: SeedWidth] = cur;
            cur = {cur[0], cur[SeedWidth-1:1]} ^ {cur[SeedWidth-2:0], cur[SeedWidth-1]};
        end
    endfunction

    // Rotate left by sh bits, using the upper half of a doubled copy.
    function automatic logic [HVDimension-1:0] rotl(input logic [HVDimension-1:0] hv,
                                                    input logic [IdxWidth-1:0] sh);
        logic [2*HVDimension-1:0] dbl;
        dbl = {hv, hv} << sh;
        return dbl[2*HVDimension-1:HVDimension];
    endfunction

    // Expand every bank seed, then select and rotate one bank for each side.
    always_comb begin
        for (int s = 0; s < NumImSets; s++) begin
            w_baseHv[s] = ca90Expand(i_seeds[s]);
        end
        o_hv_a = rotl(w_baseHv[i_addr_a[ImAddrWidth-1:IdxWidth]], i_addr_a[IdxWidth-1:0]);
        o_hv_b = rotl(w_baseHv[i_addr_b[ImAddrWidth-1:IdxWidth]], i_addr_b[IdxWidth-1:0]);
    end
endmodule

module item_memory_mp #(
    parameter int HVDimension  = 512,
    parameter int NumTotIm     = 1024,
    parameter int NumPerImBank = 128,
    parameter int SeedWidth    = 32,
    parameter int NumPorts     = 2,
    parameter int ExtWidth     = 5,
    parameter int ImAddrWidth  = $clog2(NumTotIm),
    parameter int NumImSets    = NumTotIm/NumPerImBank,
    parameter int CimSelWidth  = $clog2(HVDimension/2)
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic                                 clear_i,
    input  logic [NumPorts-1:0]                  port_cim_i,
    input  logic [SeedWidth-1:0]                 cim_seed_hv_i,
    input  logic [NumImSets-1:0][SeedWidth-1:0]  im_seed_hv_i,
    input  logic [ExtWidth-1:0]                  extend_count_i,
    input  logic                                 req_valid_i,
    output logic                                 req_ready_o,
    input  logic [NumPorts-1:0][ImAddrWidth-1:0] req_addr_i,
    output logic                                 rsp_valid_o,
    input  logic                                 rsp_ready_i,
    output logic [NumPorts-1:0][HVDimension-1:0] rsp_hv_o,
    output logic                                 rsp_last_o
);
    localparam int NumCa = (NumPorts + 1) / 2;

    typedef enum logic {IDLE, BUSY} state_e;

    state_e                             r_state;
    logic [ExtWidth-1:0]                r_k;
    logic [ExtWidth-1:0]                r_n;
    logic [NumPorts-1:0][ImAddrWidth-1:0] r_addr;

    logic                   w_load;
    logic                   w_accept;
    logic                   w_segLast;
    logic [ExtWidth-1:0]    w_n;
    logic [ImAddrWidth-1:0] w_lookAddr [NumPorts];
    logic [CimSelWidth-1:0] w_level    [NumPorts];
    logic [HVDimension-1:0] w_imHv     [NumPorts];
    logic [HVDimension-1:0] w_cimHv    [NumPorts];
    logic [HVDimension-1:0] w_segHv    [NumPorts];

    assign w_load      = !rsp_valid_o || rsp_ready_i;
    assign req_ready_o = (r_state == IDLE) && w_load && !clear_i;
    assign w_accept    = req_valid_i && req_ready_o;
    assign w_n         = (extend_count_i == '0) ? ExtWidth'(1) : extend_count_i;
    assign w_segLast   = (r_k == r_n - ExtWidth'(1));

    // In IDLE, segment 0 is looked up straight from the incoming request.
    // In BUSY, the latched base address is offset by the segment index. The
    // sum is truncated to ImAddrWidth bits, so the address wraps around the
    // memory. The port select is applied per load cycle and is never latched.
    always_comb begin
        for (int p = 0; p < NumPorts; p++) begin
            if (r_state == IDLE) begin
                w_lookAddr[p] = req_addr_i[p];
                w_level[p]    = req_addr_i[p][CimSelWidth-1:0];
            end else begin
                w_lookAddr[p] = ImAddrWidth'(r_addr[p] + ImAddrWidth'(r_k));
                w_level[p]    = r_addr[p][CimSelWidth-1:0];
            end
            w_segHv[p] = port_cim_i[p] ? w_cimHv[p] : w_imHv[p];
        end
    end

    for (genvar j = 0; j < NumCa; j++) begin : g_ca
        logic [ImAddrWidth-1:0] w_addrB;
        logic [HVDimension-1:0] w_hvB;

        if (2*j + 1 < NumPorts) begin : g_pair
            assign w_addrB         = w_lookAddr[2*j+1];
            assign w_imHv[2*j+1]   = w_hvB;
        end else begin : g_single
            assign w_addrB = '0;
        end

        ca90_item_memory #(
            .HVDimension  (HVDimension),
            .NumTotIm     (NumTotIm),
            .NumPerImBank (NumPerImBank),
            .SeedWidth    (SeedWidth)
        ) u_ca90 (
            .i_seeds  (im_seed_hv_i),
            .i_addr_a (w_lookAddr[2*j]),
            .i_addr_b (w_addrB),
            .o_hv_a   (w_imHv[2*j]),
            .o_hv_b   (w_hvB)
        );
    end

    for (genvar p = 0; p < NumPorts; p++) begin : g_cim
        cim #(
            .HVDimension (HVDimension),
            .SeedWidth   (SeedWidth),
            .CimSelWidth (CimSelWidth)
        ) u_cim (
            .i_seed  (cim_seed_hv_i),
            .i_level (w_level[p]),
            .o_hv    (w_cimHv[p])
        );
    end

    // Request sequencer and registered response stage.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= IDLE;
            r_k         <= '0;
            r_n         <= '0;
            r_addr      <= '0;
            rsp_valid_o <= 1'b0;
            rsp_last_o  <= 1'b0;
            rsp_hv_o    <= '0;
        end else if (clear_i) begin
            r_state     <= IDLE;
            r_k         <= '0;
            rsp_valid_o <= 1'b0;
            rsp_last_o  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_addr      <= req_addr_i;
                        r_n         <= w_n;
                        rsp_valid_o <= 1'b1;
                        rsp_last_o  <= (w_n == ExtWidth'(1));
                        for (int p = 0; p < NumPorts; p++) begin
                            rsp_hv_o[p] <= w_segHv[p];
                        end
                        if (w_n != ExtWidth'(1)) begin
                            r_state <= BUSY;
                            r_k     <= ExtWidth'(1);
                        end
                    end else if (w_load) begin
                        rsp_valid_o <= 1'b0;
                        rsp_last_o  <= 1'b0;
                    end
                end
                BUSY: begin
                    if (rsp_ready_i) begin
                        rsp_valid_o <= 1'b1;
                        rsp_last_o  <= w_segLast;
                        for (int p = 0; p < NumPorts; p++) begin
                            rsp_hv_o[p] <= w_segHv[p];
                        end
                        if (w_segLast) begin
                            r_state <= IDLE;
                            r_k     <= '0;
                        end else begin
                            r_k <= r_k + ExtWidth'(1);
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_k     <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_item_memory_mp.sv
// Directed testbench for item_memory_mp at its default parameters.
// Expected hypervectors come from a bit-level model of CA90 expansion,
// bank rotation and CiM level flipping.
module tb_item_memory_mp;
    logic             clk_i;
    logic             rst_ni;
    logic             clear_i;
    logic [1:0]       port_cim_i;
    logic [31:0]      cim_seed_hv_i;
    logic [7:0][31:0] im_seed_hv_i;
    logic [4:0]       extend_count_i;
    logic             req_valid_i;
    logic             req_ready_o;
    logic [1:0][9:0]  req_addr_i;
    logic             rsp_valid_o;
    logic             rsp_ready_i;
    logic [1:0][511:0] rsp_hv_o;
    logic             rsp_last_o;

    int nChecks;
    int nPass;

    item_memory_mp dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .clear_i        (clear_i),
        .port_cim_i     (port_cim_i),
        .cim_seed_hv_i  (cim_seed_hv_i),
        .im_seed_hv_i   (im_seed_hv_i),
        .extend_count_i (extend_count_i),
        .req_valid_i    (req_valid_i),
        .req_ready_o    (req_ready_o),
        .req_addr_i     (req_addr_i),
        .rsp_valid_o    (rsp_valid_o),
        .rsp_ready_i    (rsp_ready_i),
        .rsp_hv_o       (rsp_hv_o),
        .rsp_last_o     (rsp_last_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    function automatic logic [511:0] expandModel(input logic [31:0] seed);
        logic [31:0]  cur;
        logic [31:0]  nxt;
        logic [511:0] hv;
        cur = seed;
        for (int c = 0; c < 16; c++) begin
            for (int i = 0; i < 32; i++) hv[c*32+i] = cur[i];
            for (int i = 0; i < 32; i++) nxt[i] = cur[(i+31)%32] ^ cur[(i+1)%32];
            cur = nxt;
        end
        return hv;
    endfunction

    function automatic logic [511:0] imModel(input int addr);
        int a;
        int idx;
        logic [511:0] base;
        logic [511:0] hv;
        a    = addr % 1024;
        idx  = a % 128;
        base = expandModel(im_seed_hv_i[a/128]);
        for (int i = 0; i < 512; i++) hv[i] = base[(i - idx + 512) % 512];
        return hv;
    endfunction

    function automatic logic [511:0] cimModel(input int level);
        logic [511:0] base;
        logic [511:0] hv;
        base = expandModel(cim_seed_hv_i);
        for (int i = 0; i < 512; i++) hv[i] = base[i] ^ (i < level);
        return hv;
    endfunction

    task automatic tick();
        @(negedge clk_i);
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        tick();
        tick();
        nChecks++;
        if (rsp_valid_o !== 1'b0) $display("[TB] FAIL reset_valid got=%b exp=0", rsp_valid_o);
        else nPass++;
        nChecks++;
        if (rsp_last_o !== 1'b0) $display("[TB] FAIL reset_last got=%b exp=0", rsp_last_o);
        else nPass++;
        nChecks++;
        if (rsp_hv_o !== '0) $display("[TB] FAIL reset_hv got=%h exp=0", rsp_hv_o[0]);
        else nPass++;
        rst_ni = 1'b1;
        #1;
        nChecks++;
        if (req_ready_o !== 1'b1) $display("[TB] FAIL reset_ready got=%b exp=1", req_ready_o);
        else nPass++;
        tick();
    endtask

    task automatic test_wrap();
        req_addr_i[0] = 10'd1022;
        req_addr_i[1] = 10'd1;
        extend_count_i = 5'd4;
        req_valid_i = 1'b1;
        #1;
        nChecks++;
        if (req_ready_o !== 1'b1) $display("[TB] FAIL wrap_ready got=%b exp=1", req_ready_o);
        else nPass++;
        tick();
        req_valid_i = 1'b0;
        req_addr_i[0] = 10'd77;
        req_addr_i[1] = 10'd555;
        extend_count_i = 5'd9;
        for (int k = 0; k < 4; k++) begin
            nChecks++;
            if (rsp_valid_o !== 1'b1) $display("[TB] FAIL wrap_valid k=%0d got=%b exp=1", k, rsp_valid_o);
            else nPass++;
            nChecks++;
            if (rsp_hv_o[0] !== imModel(1022 + k))
                $display("[TB] FAIL wrap_hv0 k=%0d got=%h exp=%h", k, rsp_hv_o[0], imModel(1022 + k));
            else nPass++;
            nChecks++;
            if (rsp_hv_o[1] !== imModel(1 + k))
                $display("[TB] FAIL wrap_hv1 k=%0d got=%h exp=%h", k, rsp_hv_o[1], imModel(1 + k));
            else nPass++;
            nChecks++;
            if (rsp_last_o !== (k == 3)) $display("[TB] FAIL wrap_last k=%0d got=%b exp=%b", k, rsp_last_o, (k == 3));
            else nPass++;
            tick();
        end
        nChecks++;
        if (rsp_valid_o !== 1'b0) $display("[TB] FAIL wrap_drain got=%b exp=0", rsp_valid_o);
        else nPass++;
    endtask

    task automatic test_single();
        req_addr_i[0] = 10'd5;
        req_addr_i[1] = 10'd6;
        extend_count_i = 5'd0;
        req_valid_i = 1'b1;
        tick();
        req_valid_i = 1'b0;
        #1;
        nChecks++;
        if (rsp_hv_o[0] !== imModel(5)) $display("[TB] FAIL single_hv got=%h exp=%h", rsp_hv_o[0], imModel(5));
        else nPass++;
        nChecks++;
        if (rsp_valid_o !== 1'b1 || rsp_last_o !== 1'b1)
            $display("[TB] FAIL single_flags got=%b%b exp=11", rsp_valid_o, rsp_last_o);
        else nPass++;
        nChecks++;
        if (req_ready_o !== 1'b1) $display("[TB] FAIL single_ready got=%b exp=1", req_ready_o);
        else nPass++;
        tick();
        nChecks++;
        if (rsp_valid_o !== 1'b0) $display("[TB] FAIL single_drain got=%b exp=0", rsp_valid_o);
        else nPass++;
    endtask

    task automatic test_cim_mix();
        port_cim_i = 2'b01;
        req_addr_i[0] = 10'd17;
        req_addr_i[1] = 10'd300;
        extend_count_i = 5'd3;
        req_valid_i = 1'b1;
        tick();
        req_valid_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            nChecks++;
            if (rsp_hv_o[0] !== cimModel(17))
                $display("[TB] FAIL cim_hv0 k=%0d got=%h exp=%h", k, rsp_hv_o[0], cimModel(17));
            else nPass++;
            nChecks++;
            if (rsp_hv_o[1] !== imModel(300 + k))
                $display("[TB] FAIL cim_hv1 k=%0d got=%h exp=%h", k, rsp_hv_o[1], imModel(300 + k));
            else nPass++;
            nChecks++;
            if (rsp_last_o !== (k == 2)) $display("[TB] FAIL cim_last k=%0d got=%b exp=%b", k, rsp_last_o, (k == 2));
            else nPass++;
            tick();
        end
        port_cim_i = 2'b00;
    endtask

    task automatic test_backpressure();
        req_addr_i[0] = 10'd700;
        req_addr_i[1] = 10'd0;
        extend_count_i = 5'd3;
        req_valid_i = 1'b1;
        tick();
        req_valid_i = 1'b0;
        nChecks++;
        if (rsp_hv_o[0] !== imModel(700)) $display("[TB] FAIL bp_beat0 got=%h exp=%h", rsp_hv_o[0], imModel(700));
        else nPass++;
        rsp_ready_i = 1'b0;
        for (int s = 0; s < 5; s++) begin
            tick();
            nChecks++;
            if (rsp_hv_o[0] !== imModel(700) || rsp_last_o !== 1'b0 || rsp_valid_o !== 1'b1)
                $display("[TB] FAIL bp_hold s=%0d got=%h last=%b valid=%b exp=%h last=0 valid=1",
                         s, rsp_hv_o[0], rsp_last_o, rsp_valid_o, imModel(700));
            else nPass++;
            nChecks++;
            if (req_ready_o !== 1'b0) $display("[TB] FAIL bp_ready s=%0d got=%b exp=0", s, req_ready_o);
            else nPass++;
        end
        rsp_ready_i = 1'b1;
        for (int k = 1; k < 3; k++) begin
            tick();
            nChecks++;
            if (rsp_hv_o[0] !== imModel(700 + k) || rsp_last_o !== (k == 2))
                $display("[TB] FAIL bp_beat k=%0d got=%h last=%b exp=%h last=%b",
                         k, rsp_hv_o[0], rsp_last_o, imModel(700 + k), (k == 2));
            else nPass++;
        end
        tick();
        nChecks++;
        if (rsp_valid_o !== 1'b0) $display("[TB] FAIL bp_drain got=%b exp=0", rsp_valid_o);
        else nPass++;
    endtask

    task automatic test_back_to_back();
        req_addr_i[0] = 10'd100;
        extend_count_i = 5'd2;
        req_valid_i = 1'b1;
        tick();
        req_addr_i[0] = 10'd200;
        #1;
        nChecks++;
        if (req_ready_o !== 1'b0) $display("[TB] FAIL b2b_busy_ready got=%b exp=0", req_ready_o);
        else nPass++;
        nChecks++;
        if (rsp_hv_o[0] !== imModel(100) || rsp_last_o !== 1'b0)
            $display("[TB] FAIL b2b_a0 got=%h last=%b exp=%h last=0", rsp_hv_o[0], rsp_last_o, imModel(100));
        else nPass++;
        tick();
        #1;
        nChecks++;
        if (rsp_hv_o[0] !== imModel(101) || rsp_last_o !== 1'b1)
            $display("[TB] FAIL b2b_a1 got=%h last=%b exp=%h last=1", rsp_hv_o[0], rsp_last_o, imModel(101));
        else nPass++;
        nChecks++;
        if (req_ready_o !== 1'b1) $display("[TB] FAIL b2b_pop_ready got=%b exp=1", req_ready_o);
        else nPass++;
        tick();
        req_valid_i = 1'b0;
        nChecks++;
        if (rsp_valid_o !== 1'b1 || rsp_hv_o[0] !== imModel(200) || rsp_last_o !== 1'b0)
            $display("[TB] FAIL b2b_b0 got=%h last=%b valid=%b exp=%h last=0 valid=1",
                     rsp_hv_o[0], rsp_last_o, rsp_valid_o, imModel(200));
        else nPass++;
        tick();
        nChecks++;
        if (rsp_hv_o[0] !== imModel(201) || rsp_last_o !== 1'b1)
            $display("[TB] FAIL b2b_b1 got=%h last=%b exp=%h last=1", rsp_hv_o[0], rsp_last_o, imModel(201));
        else nPass++;
        tick();
    endtask

    task automatic test_clear();
        req_addr_i[0] = 10'd400;
        extend_count_i = 5'd8;
        req_valid_i = 1'b1;
        tick();
        req_valid_i = 1'b0;
        tick();
        nChecks++;
        if (rsp_hv_o[0] !== imModel(401)) $display("[TB] FAIL clr_beat1 got=%h exp=%h", rsp_hv_o[0], imModel(401));
        else nPass++;
        clear_i = 1'b1;
        req_valid_i = 1'b1;
        req_addr_i[0] = 10'd50;
        extend_count_i = 5'd2;
        #1;
        nChecks++;
        if (req_ready_o !== 1'b0) $display("[TB] FAIL clr_ready got=%b exp=0", req_ready_o);
        else nPass++;
        tick();
        clear_i = 1'b0;
        #1;
        nChecks++;
        if (rsp_valid_o !== 1'b0 || rsp_last_o !== 1'b0)
            $display("[TB] FAIL clr_flush got=%b%b exp=00", rsp_valid_o, rsp_last_o);
        else nPass++;
        nChecks++;
        if (req_ready_o !== 1'b1) $display("[TB] FAIL clr_after_ready got=%b exp=1", req_ready_o);
        else nPass++;
        tick();
        req_valid_i = 1'b0;
        nChecks++;
        if (rsp_hv_o[0] !== imModel(50) || rsp_last_o !== 1'b0)
            $display("[TB] FAIL clr_new0 got=%h last=%b exp=%h last=0", rsp_hv_o[0], rsp_last_o, imModel(50));
        else nPass++;
        tick();
        nChecks++;
        if (rsp_hv_o[0] !== imModel(51) || rsp_last_o !== 1'b1)
            $display("[TB] FAIL clr_new1 got=%h last=%b exp=%h last=1", rsp_hv_o[0], rsp_last_o, imModel(51));
        else nPass++;
        tick();
    endtask

    task automatic test_reset_mid();
        req_addr_i[0] = 10'd900;
        extend_count_i = 5'd8;
        req_valid_i = 1'b1;
        tick();
        req_valid_i = 1'b0;
        tick();
        #2;
        rst_ni = 1'b0;
        #1;
        nChecks++;
        if (rsp_valid_o !== 1'b0 || rsp_last_o !== 1'b0 || rsp_hv_o !== '0)
            $display("[TB] FAIL rstmid_async got valid=%b last=%b hv=%h exp=0", rsp_valid_o, rsp_last_o, rsp_hv_o[0]);
        else nPass++;
        tick();
        rst_ni = 1'b1;
        for (int s = 0; s < 3; s++) begin
            tick();
            nChecks++;
            if (rsp_valid_o !== 1'b0) $display("[TB] FAIL rstmid_quiet s=%0d got=%b exp=0", s, rsp_valid_o);
            else nPass++;
        end
        req_addr_i[0] = 10'd1023;
        extend_count_i = 5'd2;
        req_valid_i = 1'b1;
        tick();
        req_valid_i = 1'b0;
        nChecks++;
        if (rsp_hv_o[0] !== imModel(1023) || rsp_last_o !== 1'b0)
            $display("[TB] FAIL rstmid_new0 got=%h last=%b exp=%h last=0", rsp_hv_o[0], rsp_last_o, imModel(1023));
        else nPass++;
        tick();
        nChecks++;
        if (rsp_hv_o[0] !== imModel(0) || rsp_last_o !== 1'b1)
            $display("[TB] FAIL rstmid_new1 got=%h last=%b exp=%h last=1", rsp_hv_o[0], rsp_last_o, imModel(0));
        else nPass++;
        tick();
    endtask

    initial begin
        nChecks = 0;
        nPass = 0;
        rst_ni = 1'b0;
        clear_i = 1'b0;
        port_cim_i = 2'b00;
        cim_seed_hv_i = 32'h1234_5678;
        im_seed_hv_i[0] = 32'hDEAD_BEEF;
        im_seed_hv_i[1] = 32'h0BAD_F00D;
        im_seed_hv_i[2] = 32'hCAFE_BABE;
        im_seed_hv_i[3] = 32'h8000_0001;
        im_seed_hv_i[4] = 32'h1357_9BDF;
        im_seed_hv_i[5] = 32'h2468_ACE0;
        im_seed_hv_i[6] = 32'hF0F0_0F0F;
        im_seed_hv_i[7] = 32'h7A5C_3E91;
        extend_count_i = 5'd0;
        req_valid_i = 1'b0;
        req_addr_i = '0;
        rsp_ready_i = 1'b1;

        test_reset();
        test_wrap();
        test_single();
        test_cim_mix();
        test_backpressure();
        test_back_to_back();
        test_clear();
        test_reset_mid();

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end
endmodule
